// File: rtl/alu_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_vector_checker
// Purpose  : Drives ALU operand/opcode vectors, samples the ALU outputs after
//            a fixed latency and checks them against a built-in golden model.
//            Reports pass/fail, a saturating error count and the first
//            failing vector.
// Revision : 1.0 - initial release
// ============================================================================
module alu_vector_checker #(
  parameter int          W     = 32,
  parameter int          N_VEC = 16,
  parameter int          LAT   = 0,
  parameter logic [31:0] SEED  = 32'h1ACE_B00C
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [2:0]   ALUOp,
  input  logic [W-1:0] result,
  input  logic         c_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic [2:0]   fail_op,
  output logic [W-1:0] fail_a,
  output logic [W-1:0] fail_b
);

  localparam int                HOLD_W    = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int                VEC_W     = $clog2(N_VEC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LAT);
  localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(N_VEC - 1);
  localparam logic [2:0]        OPI_LAST  = 3'd5;
  localparam logic [31:0]       LFSR_MASK = 32'h8020_0003;
  localparam logic [W-1:0]      A_FORCED  = {W{1'b1}};
  localparam logic [W-1:0]      B_FORCED  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d;
  logic [2:0]          op_q, op_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]         err_q, err_d;
  logic [2:0]          fop_q, fop_d;
  logic [W-1:0]        fa_q, fa_d, fb_q, fb_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [2:0]          opi_q, opi_d;
  logic [31:0]         lfa_q, lfa_d, lfb_q, lfb_d;
  logic [W:0]          golden;
  logic                mismatch;

  // Opcode visited at each position of the run; 010 and 111 are skipped.
  function automatic logic [2:0] op_of(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return 3'b011;
      3'd3:    return 3'b100;
      3'd4:    return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  // Right-shifting Galois LFSR, x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  // Golden {carry, result} for the vector currently on the ALU inputs.
  always_comb begin
    golden = '0;
    case (op_q)
      3'b000:  golden = {1'b0, a_q};
      3'b001:  golden = ~{1'b0, a_q};
      3'b011:  golden = {1'b0, a_q & b_q};
      3'b100:  golden = {1'b0, a_q | b_q};
      3'b101:  golden = {1'b0, a_q} + {1'b1, ~b_q} + {{W{1'b0}}, 1'b1};
      3'b110:  golden = {1'b0, a_q} + {1'b0, b_q};
      default: golden = '0;
    endcase
    mismatch = ({c_out, result} != golden);
  end

  // Next-state logic: run sequencing, compare and first-failure capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fop_d   = fop_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    opi_d   = opi_q;
    lfa_d   = lfa_q;
    lfb_d   = lfb_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = A_FORCED;
          b_d     = B_FORCED;
          op_d    = 3'b000;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fop_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
          hold_d  = '0;
          vec_d   = '0;
          opi_d   = '0;
          lfa_d   = SEED;
          lfb_d   = ~SEED;
        end
      end
      ST_RUN: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end else begin
          hold_d = '0;
          // Compare and move to the next vector on the same edge.
          if (mismatch) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'h0000) begin
              fop_d = op_q;
              fa_d  = a_q;
              fb_d  = b_q;
            end
          end
          if (vec_q == VEC_LAST) begin
            vec_d = '0;
            if (opi_q == OPI_LAST) begin
              // Operands stay on the last vector; pass reflects the whole run.
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_q == 16'h0000) && !mismatch;
            end else begin
              opi_d = opi_q + 3'd1;
              op_d  = op_of(opi_q + 3'd1);
              a_d   = A_FORCED;
              b_d   = B_FORCED;
            end
          end else begin
            vec_d = vec_q + 1'b1;
            a_d   = lfa_q[W-1:0];
            b_d   = lfb_q[W-1:0];
            lfa_d = lfsr_step(lfa_q);
            lfb_d = lfsr_step(lfb_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fop_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      hold_q  <= '0;
      vec_q   <= '0;
      opi_q   <= '0;
      lfa_q   <= SEED;
      lfb_q   <= ~SEED;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fop_q   <= fop_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      opi_q   <= opi_d;
      lfa_q   <= lfa_d;
      lfb_q   <= lfb_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign ALUOp     = op_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_op   = fop_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;

endmodule
`default_nettype wire

// File: doc/alu_vector_checker.md
# alu_vector_checker

Self-checking stimulus initiator for the ALU: drives operand pairs and `ALUOp` codes into an ALU under test, waits a programmable latency, samples `result`/`c_out`, and compares them against an internal golden computation. It drives the ALU's inputs and consumes its outputs, sitting in the lab testbench or an on-board self-test wrapper. It reports pass/fail, a saturating error count and the first failing vector.

## Interface
- `W`, 32: operand/result width, legal range 8..32.
- `N_VEC`, 16: vectors per opcode, at least 2.
- `LAT`, 0: DUT latency in cycles, at least 0. 0 means a combinational DUT.
- `SEED`, 32'h1ACE_B00C: LFSR seed. Must be nonzero.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a run when sampled high in IDLE or DONE.
- `a`, `b`  out  W  registered operands to the DUT.
- `ALUOp`  out  3  registered opcode to the DUT.
- `result`  in  W  DUT result.
- `c_out`  in  1  DUT carry out.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from run end until the next start.
- `pass`  out  1  valid when `done`=1; 1 means zero mismatches.
- `err_count`  out  16  mismatch count; saturates at 16'hFFFF.
- `fail_op`  out  3  opcode of the first mismatch.
- `fail_a`, `fail_b`  out  W  operands of the first mismatch.

## Operation
- States:
  - IDLE, then RUN on `start`.
  - RUN, then DONE after the last compare.
  - DONE, then RUN on `start`.
- Opcode sequence, in this order: 000, 001, 011, 100, 101, 110. Codes 010 and 111 are never driven.
- Each opcode gets `N_VEC` vectors.
- Vector 0 of every opcode is forced to a={W{1}}, b={{W-1{0}},1}.
- Vectors 1..N_VEC-1 use two 32-bit Galois LFSRs, polynomial x^32+x^22+x^2+x+1 (toggle mask 32'h8020_0003).
  - The a-LFSR is seeded `SEED`; the b-LFSR is seeded ~`SEED`.
  - Operands are the LFSRs' low W bits.
  - Both LFSRs step once per LFSR-sourced vector and run continuously across opcodes.
  - Both re-seed on every `start`.
- Golden model, computed as a W+1-bit value {c,r}:
  - 000: c=0, r=a.
  - 001: c=1, r=~a (the operand is zero-extended, then inverted).
  - 011: c=0, r=a&b.
  - 100: c=0, r=a|b.
  - 101: {c,r} = {1'b0,a} + {1'b1,~b} + 1 mod 2^(W+1). This gives c=1 exactly when a<b unsigned.
  - 110: {c,r} = {1'b0,a} + {1'b0,b}.
- Compare both `result` and `c_out`. A mismatch in either field counts as a mismatch.
- On a mismatch:
  - `err_count` increments, saturating.
  - On the first mismatch only, `fail_op`/`fail_a`/`fail_b` latch the vector.
- `pass` = (`err_count`==0), updated on entry to DONE.
- `start` while in RUN is ignored.
- `start` in DONE clears `err_count`, `fail_*`, `pass` and `done`, then starts a new run.

## Timing
- Reset (`rst_n`=0, asynchronous, at any time including mid-run):
  - State goes to IDLE.
  - `a`, `b`, `ALUOp`, `busy`, `done`, `pass`, `err_count` and `fail_*` all go to 0.
  - LFSRs reload to their seeds.
- Edge E0, where `start` is sampled high in IDLE or DONE:
  - Vector 0 of op 000 is registered onto `a`/`b`/`ALUOp`.
  - `busy` goes to 1 and the hold counter is cleared.
- Each vector is held for LAT+1 cycles.
  - On the last hold edge, `result`/`c_out` are sampled and compared.
  - On that same edge, the next vector is registered.
  - So there are no bubbles between vectors.
- The final compare happens at edge E0 + 6·N_VEC·(LAT+1). On that edge:
  - `busy` goes to 0 and `done` goes to 1.
  - `pass` is valid.
  - `a`, `b` and `ALUOp` hold the last vector.
- Counter wrap:
  - The vector index wraps from N_VEC-1 to 0 as the opcode advances.
  - After op 110, the run ends; it never wraps back to 000.

## Test plan
- Correct combinational ALU, N_VEC=4, LAT=0, `start` pulsed one cycle:
  - `busy` holds for exactly 24 cycles.
  - Then `done`=1, `pass`=1, `err_count`=0.
  - `ALUOp` visits 000, 001, 011, 100, 101, 110, four cycles each.
- DUT with the carry on 110 tied to 0, N_VEC=4:
  - `fail_op`=110, `fail_a`=FFFF_FFFF, `fail_b`=0000_0001 (expected r=0, c=1).
  - `pass`=0, `err_count`≥1.
- Correct DUT with two output register stages, LAT=2, N_VEC=4:
  - `done` goes high 72 cycles after E0; `pass`=1.
  - The same DUT with LAT=0 gives `pass`=0.
- Reset asserted asynchronously mid-cycle during op 100:
  - All outputs go to 0 immediately.
  - A subsequent `start` reproduces identical `a`/`b` sequences, because the LFSRs re-seed.
- Apply `start` again at the 10th cycle of a run:
  - The run length is unchanged.
  - After `done`, a new `start` clears `err_count`/`pass`/`done`/`fail_*` on E0.
- DUT returning 0 for every result, with N_VEC=2 and SEED=1:
  - `err_count` ends at 12 minus the number of vectors whose golden {c,r} is 0.
  - The saturation logic is exercised separately by forcing `err_count` to 16'hFFFE, then injecting two mismatches. `err_count` must read 16'hFFFF.
